// File: rtl/sw_reg_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// sw_reg_cmd_sequencer
//
// Interprets the 32-bit word presented by the PPC->Simulink software register
// as a command, in the user clock domain. Bit 31 is a toggle: software issues
// (or re-issues) a command by flipping it. Commands produce a pulse, an arm
// level, or a delayed one-cycle trigger.
//
// Word layout: [31] toggle, [30:28] opcode, [ARG_W-1:0] argument.
//   0 NOP, 1 PULSE (max(arg,1) cycles), 2 ARM, 3 DISARM,
//   4 DELAY_PULSE (wait max(arg,1) cycles, then 1-cycle pulse), 5-7 reserved.
//
// Ports:
//   user_clk     in   1           user clock
//   user_rst     in   1           asynchronous active-high reset
//   user_data_in in   32          software register word (may be X before first write)
//   cmd_strobe   out  1           one-cycle pulse when a command is accepted
//   pulse_out    out  1           PULSE / DELAY_PULSE output
//   arm_out      out  1           set by ARM, cleared by DISARM
//   busy         out  1           high while a PULSE/DELAY_PULSE is in progress
//   err_opcode   out  1           sticky flag, set by a reserved opcode
//   cmd_count    out  CMD_CNT_W   accepted commands, wraps
//   drop_count   out  DROP_CNT_W  commands discarded while busy, saturates
// -----------------------------------------------------------------------------
module sw_reg_cmd_sequencer #(
    parameter int ARG_W      = 28,
    parameter int CMD_CNT_W  = 16,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  user_clk,
    input  logic                  user_rst,
    input  logic [31:0]           user_data_in,
    output logic                  cmd_strobe,
    output logic                  pulse_out,
    output logic                  arm_out,
    output logic                  busy,
    output logic                  err_opcode,
    output logic [CMD_CNT_W-1:0]  cmd_count,
    output logic [DROP_CNT_W-1:0] drop_count
);

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_IDLE,
        ST_DELAY,
        ST_PULSE
    } state_t;

    localparam logic [ARG_W-1:0]      ARG_ONE  = ARG_W'(1);
    localparam logic [CMD_CNT_W-1:0]  CMD_ONE  = CMD_CNT_W'(1);
    localparam logic [DROP_CNT_W-1:0] DROP_ONE = DROP_CNT_W'(1);

    state_t           r_state;
    logic [31:0]      r_data_q;
    logic             r_last_tog;
    logic [ARG_W-1:0] r_cnt;

    logic             w_new_cmd;
    logic [2:0]       w_opcode;
    logic [ARG_W-1:0] w_arg;
    logic [ARG_W-1:0] w_load;
    logic             w_drop;

    // The input register is deliberately not reset: after reset the SYNC
    // cycle must sample the word software is actually holding, so that an
    // unchanged word is never mistaken for a fresh toggle.
    always_ff @(posedge user_clk) begin
        r_data_q <= user_data_in;
    end

    always_comb begin
        w_new_cmd = (r_data_q[31] != r_last_tog);
        w_opcode  = r_data_q[30:28];
        w_arg     = r_data_q[ARG_W-1:0];
        // Counter runs down to zero, so load max(arg,1)-1.
        w_load    = (w_arg == '0) ? '0 : (w_arg - ARG_ONE);
        w_drop    = w_new_cmd && (drop_count != '1);
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            r_state    <= ST_SYNC;
            r_last_tog <= 1'b0;
            r_cnt      <= '0;
            cmd_strobe <= 1'b0;
            pulse_out  <= 1'b0;
            arm_out    <= 1'b0;
            busy       <= 1'b0;
            err_opcode <= 1'b0;
            cmd_count  <= '0;
            drop_count <= '0;
        end else begin
            cmd_strobe <= 1'b0;
            // In SYNC this captures the pre-existing toggle; elsewhere it
            // consumes each flip exactly once, whether executed or dropped.
            r_last_tog <= r_data_q[31];

            case (r_state)
                ST_SYNC: begin
                    r_state <= ST_IDLE;
                end

                ST_IDLE: begin
                    if (w_new_cmd) begin
                        cmd_strobe <= 1'b1;
                        cmd_count  <= cmd_count + CMD_ONE;
                        case (w_opcode)
                            3'd0: ;
                            3'd1: begin
                                pulse_out <= 1'b1;
                                busy      <= 1'b1;
                                r_cnt     <= w_load;
                                r_state   <= ST_PULSE;
                            end
                            3'd2: arm_out <= 1'b1;
                            3'd3: arm_out <= 1'b0;
                            3'd4: begin
                                busy    <= 1'b1;
                                r_cnt   <= w_load;
                                r_state <= ST_DELAY;
                            end
                            default: err_opcode <= 1'b1;
                        endcase
                    end
                end

                ST_DELAY: begin
                    if (w_drop) begin
                        drop_count <= drop_count + DROP_ONE;
                    end
                    if (r_cnt == '0) begin
                        // Trigger is a single cycle: PULSE with count 0.
                        pulse_out <= 1'b1;
                        r_state   <= ST_PULSE;
                    end else begin
                        r_cnt <= r_cnt - ARG_ONE;
                    end
                end

                ST_PULSE: begin
                    if (w_drop) begin
                        drop_count <= drop_count + DROP_ONE;
                    end
                    if (r_cnt == '0) begin
                        pulse_out <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - ARG_ONE;
                    end
                end

                default: begin
                    r_state <= ST_SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sw_reg_cmd_sequencer.sv
module tb_sw_reg_cmd_sequencer;

    localparam int ARG_W      = 28;
    localparam int CMD_CNT_W  = 16;
    localparam int DROP_CNT_W = 8;

    logic                  user_clk = 1'b0;
    logic                  user_rst = 1'b1;
    logic [31:0]           user_data_in;
    logic                  cmd_strobe;
    logic                  pulse_out;
    logic                  arm_out;
    logic                  busy;
    logic                  err_opcode;
    logic [CMD_CNT_W-1:0]  cmd_count;
    logic [DROP_CNT_W-1:0] drop_count;

    int checks = 0;
    int errors = 0;

    logic                 tog = 1'b0;
    logic [CMD_CNT_W-1:0] exp_cnt = '0;
    int                   exp_drop = 0;
    int                   q_strobe[$];
    int                   q_pulse[$];
    int                   run = 0;

    sw_reg_cmd_sequencer #(
        .ARG_W(ARG_W),
        .CMD_CNT_W(CMD_CNT_W),
        .DROP_CNT_W(DROP_CNT_W)
    ) dut (
        .user_clk(user_clk),
        .user_rst(user_rst),
        .user_data_in(user_data_in),
        .cmd_strobe(cmd_strobe),
        .pulse_out(pulse_out),
        .arm_out(arm_out),
        .busy(busy),
        .err_opcode(err_opcode),
        .cmd_count(cmd_count),
        .drop_count(drop_count)
    );

    always #5 user_clk = ~user_clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: every strobe must match a queued cmd_count, every
    // completed pulse_out run must match a queued width.
    always @(negedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            run = 0;
        end else begin
            if (cmd_strobe) begin
                if (q_strobe.size() == 0) check("unexpected_strobe", 1, 0);
                else check("strobe_cmd_count", cmd_count, q_strobe.pop_front());
            end
            if (pulse_out) begin
                run++;
            end else if (run > 0) begin
                if (q_pulse.size() == 0) check("unexpected_pulse", run, 0);
                else check("pulse_width", run, q_pulse.pop_front());
                run = 0;
            end
        end
    end

    // Drive a fresh command (toggle flipped) and queue what it must produce.
    task automatic issue(input logic [2:0] op, input int unsigned arg);
        logic [27:0] a;
        a   = arg[27:0];
        tog = ~tog;
        @(negedge user_clk);
        user_data_in = {tog, op, a};
        exp_cnt++;
        q_strobe.push_back(int'(exp_cnt));
        if (op == 3'd1) q_pulse.push_back((arg == 0) ? 1 : int'(arg));
        if (op == 3'd4) q_pulse.push_back(1);
    endtask

    // Toggle while busy: must be discarded.
    task automatic toggle_drop(input logic [2:0] op);
        tog = ~tog;
        user_data_in = {tog, op, 28'd0};
        if (exp_drop < 255) exp_drop++;
    endtask

    task automatic wait_strobe(input string name, output int lat);
        lat = 0;
        while (!cmd_strobe && lat < 20) begin
            @(negedge user_clk);
            lat++;
        end
        if (!cmd_strobe) check(name, 0, 1);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            @(negedge user_clk);
            n++;
        end
        if (busy) check("busy_timeout", 1, 0);
        repeat (2) @(negedge user_clk);
    endtask

    typedef struct {
        logic [2:0]  op;
        int unsigned arg;
        bit          exp_arm;
        bit          exp_err;
        bit          exp_busy;
    } vec_t;

    initial begin
        vec_t vec[9];
        int   lat;
        int   low;
        bit   busy_seen;

        vec[0] = '{3'd2, 0, 1'b1, 1'b0, 1'b0};  // ARM
        vec[1] = '{3'd3, 0, 1'b0, 1'b0, 1'b0};  // DISARM
        vec[2] = '{3'd0, 7, 1'b0, 1'b0, 1'b0};  // NOP
        vec[3] = '{3'd2, 0, 1'b1, 1'b0, 1'b0};  // ARM
        vec[4] = '{3'd1, 0, 1'b1, 1'b0, 1'b1};  // PULSE arg 0 -> 1 cycle
        vec[5] = '{3'd3, 0, 1'b0, 1'b0, 1'b0};  // DISARM
        vec[6] = '{3'd5, 0, 1'b0, 1'b1, 1'b0};  // reserved
        vec[7] = '{3'd7, 9, 1'b0, 1'b1, 1'b0};  // reserved, err stays
        vec[8] = '{3'd0, 0, 1'b0, 1'b1, 1'b0};  // NOP, err sticky

        // Reset with an undefined word, then a stale word before release.
        user_data_in = 'x;
        repeat (3) @(negedge user_clk);
        check("rst_strobe", cmd_strobe, 0);
        check("rst_pulse", pulse_out, 0);
        check("rst_arm", arm_out, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_opcode, 0);
        check("rst_cmd_count", cmd_count, 0);
        check("rst_drop_count", drop_count, 0);
        user_data_in = 32'h1000_0005;
        @(negedge user_clk);
        user_rst = 1'b0;
        repeat (6) @(negedge user_clk);
        check("sync_no_exec_count", cmd_count, 0);
        check("sync_no_exec_pulse", pulse_out, 0);

        // 0x9000_0005: 2-cycle latency, 5-cycle pulse.
        issue(3'd1, 5);
        check("word_0x90000005", user_data_in, 32'h9000_0005);
        wait_strobe("pulse5_strobe_timeout", lat);
        check("pulse5_latency", lat, 2);
        check("pulse5_pulse_with_strobe", pulse_out, 1);
        check("pulse5_busy", busy, 1);
        wait_idle(50);

        // Table of single commands issued from IDLE.
        for (int i = 0; i < 9; i++) begin
            issue(vec[i].op, vec[i].arg);
            busy_seen = 1'b0;
            lat = 0;
            while (!cmd_strobe && lat < 20) begin
                busy_seen |= busy;
                @(negedge user_clk);
                lat++;
            end
            check($sformatf("vec%0d_latency", i), lat, 2);
            repeat (4) begin
                busy_seen |= busy;
                @(negedge user_clk);
            end
            check($sformatf("vec%0d_arm", i), arm_out, vec[i].exp_arm);
            check($sformatf("vec%0d_err", i), err_opcode, vec[i].exp_err);
            check($sformatf("vec%0d_busy_seen", i), busy_seen, vec[i].exp_busy);
            check($sformatf("vec%0d_cmd_count", i), cmd_count, exp_cnt);
        end

        // DELAY_PULSE arg 3: three low cycles from strobe, then 1 high.
        issue(3'd4, 3);
        check("word_0xC0000003", user_data_in, 32'hC000_0003);
        wait_strobe("delay3_strobe_timeout", lat);
        check("delay3_busy", busy, 1);
        low = 0;
        while (!pulse_out && low < 20) begin
            low++;
            @(negedge user_clk);
        end
        check("delay3_low_cycles", low, 3);
        wait_idle(20);

        // DELAY_PULSE arg 0: one low cycle, then 1 high.
        issue(3'd4, 0);
        check("word_0x40000000", user_data_in, 32'h4000_0000);
        wait_strobe("delay0_strobe_timeout", lat);
        low = 0;
        while (!pulse_out && low < 20) begin
            low++;
            @(negedge user_clk);
        end
        check("delay0_low_cycles", low, 1);
        wait_idle(20);

        // Toggle seen in the last PULSE cycle is dropped, not executed later.
        issue(3'd1, 3);
        wait_strobe("lastcyc_strobe_timeout", lat);
        @(negedge user_clk);
        toggle_drop(3'd2);
        wait_idle(20);
        repeat (4) @(negedge user_clk);
        check("lastcyc_drop", drop_count, exp_drop);
        check("lastcyc_arm", arm_out, 0);
        check("lastcyc_cmd_count", cmd_count, exp_cnt);

        // ARM toggled mid-PULSE is dropped; arm_out holds.
        issue(3'd1, 100);
        wait_strobe("p100_strobe_timeout", lat);
        repeat (50) @(negedge user_clk);
        toggle_drop(3'd2);
        wait_idle(200);
        check("p100_arm_held", arm_out, 0);
        check("p100_drop", drop_count, exp_drop);
        check("p100_cmd_count", cmd_count, exp_cnt);

        // 300 drops saturate drop_count at all-ones.
        issue(3'd1, 2000);
        wait_strobe("p2000_strobe_timeout", lat);
        for (int i = 0; i < 300; i++) begin
            repeat (2) @(negedge user_clk);
            toggle_drop(3'd0);
        end
        wait_idle(3000);
        check("drop_saturate", drop_count, 255);
        check("drop_sat_model", exp_drop, 255);
        check("p2000_cmd_count", cmd_count, exp_cnt);
        check("err_still_sticky", err_opcode, 1);

        // Reset in the middle of a long pulse with arm_out set.
        issue(3'd2, 0);
        wait_strobe("arm_strobe_timeout", lat);
        repeat (2) @(negedge user_clk);
        check("pre_rst_arm", arm_out, 1);
        issue(3'd1, 1000);
        wait_strobe("p1000_strobe_timeout", lat);
        repeat (10) @(negedge user_clk);
        check("pre_rst_pulse", pulse_out, 1);
        #2 user_rst = 1'b1;
        #1;
        check("async_rst_pulse", pulse_out, 0);
        check("async_rst_arm", arm_out, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_err", err_opcode, 0);
        check("async_rst_cmd_count", cmd_count, 0);
        check("async_rst_drop_count", drop_count, 0);
        if (q_pulse.size() > 0) void'(q_pulse.pop_back());
        exp_cnt = '0;
        repeat (2) @(negedge user_clk);
        user_rst = 1'b0;
        repeat (20) @(negedge user_clk);
        check("post_rst_no_reexec_count", cmd_count, 0);
        check("post_rst_no_reexec_pulse", pulse_out, 0);

        check("strobe_queue_empty", q_strobe.size(), 0);
        check("pulse_queue_empty", q_pulse.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
